pipe_stall_ctrl: RTL

//  Central stall/flush controller for the 5-stage pipeline. Produces the stall[5:0] vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
//  Bit map: 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.

---
 rtl/pipe_stall_ctrl_pkg.sv | 25 ++
 rtl/pipe_stall_ctrl_sat_counter.sv | 31 +++
 rtl/pipe_stall_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// ============================================================================
// Module : pipe_stall_ctrl_pkg
// Brief  : Stall encodings and divide FSM state codes for pipe_stall_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_stall_ctrl_pkg;

  localparam logic c_STOP   = 1'b1;
  localparam logic c_NOSTOP = 1'b0;

  localparam logic [5:0] c_STALL_NONE    = 6'b000000;
  localparam logic [5:0] c_STALL_FROM_ID = 6'b000111;
  localparam logic [5:0] c_STALL_FROM_EX = 6'b001111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// ============================================================================
// Module : pipe_stall_ctrl_sat_counter
// Brief  : Increment-enable counter that sticks at all-ones; sync clear on rst.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// Module : pipe_stall_ctrl
// Brief  : Pipeline stall/flush arbiter with multi-cycle divide sequencing.
//          Optional statistics counters enabled by `PIPE_STALL_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int STAT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              div_start,
  input  logic              div_annul,
  input  logic              flush,
  output logic [5:0]        stall,
  output logic              div_busy,
  output logic              div_ready,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_CYCLES);

  div_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]       w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      DIV_IDLE: begin
        if (div_start && !flush && !div_annul) begin
          w_state_nxt = DIV_BUSY;
          w_cnt_nxt   = c_DIV_LOAD;
        end
      end
      DIV_BUSY: begin
        if (flush || div_annul) begin
          w_state_nxt = DIV_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = DIV_DONE;
          end
        end
      end
      DIV_DONE: begin
        // div_start is ignored here: the EX instruction is leaving with its result.
        w_state_nxt = DIV_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = DIV_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The issue cycle (IDLE with div_start) stalls too, giving DIV_CYCLES+1 stalled cycles.
  always_comb begin
    w_stall = c_STALL_NONE;
    if (rst || flush) begin
      w_stall = c_STALL_NONE;
    end else if ((r_state == DIV_BUSY) || ((r_state == DIV_IDLE) && div_start)) begin
      w_stall = c_STALL_FROM_EX;
    end else if (stallreq_ex) begin
      w_stall = c_STALL_FROM_EX;
    end else if (stallreq_id) begin
      w_stall = c_STALL_FROM_ID;
    end
  end

  assign stall     = w_stall;
  assign div_busy  = (r_state == DIV_BUSY);
  assign div_ready = (r_state == DIV_DONE);

`ifdef PIPE_STALL_STATS_EN
  pipe_stall_ctrl_sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall[0] == c_STOP),
    .count (stall_cycles)
  );

  pipe_stall_ctrl_sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

`default_nettype wire
